// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the seq_gen serial sequence generator.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1010;
  localparam logic [7:0] CNT_SAT = 8'hFF;

endpackage

// File: rtl/seq_gen_pattern_cnt.sv
// Overlapping 1010 counter on the emitted serial stream, saturating at CNT_SAT.
module seq_gen_pattern_cnt
  import seq_gen_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_in,
  output logic [7:0] pattern_cnt
);

  logic [2:0] hist;
  logic       hit;

  // History is fed every cycle so idle/gap zeros count just as a detector sees them.
  always_comb begin
    hit = ({hist, bit_in} == PATTERN) && (pattern_cnt != CNT_SAT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist        <= 3'b000;
      pattern_cnt <= 8'd0;
    end else begin
      hist <= {hist[1:0], bit_in};
      if (hit) pattern_cnt <= pattern_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/seq_gen.sv
// Parallel-to-serial frame generator, MSB first, with idle gap between frames.
// Optional 1010 occurrence counter enabled by SEQ_GEN_PATTERN_CNT_EN.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             out_seq,
  output logic             out_valid,
  output logic             frame_done,
  output logic [7:0]       pattern_cnt,
  output state_t           dbg_state
);

  // Handshake: a word transfers on a rising edge where data_valid && data_ready.
  // data_ready depends only on registered state (and reset), never on data_valid.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  sr;
  logic [CW-1:0]     bit_cnt;
  logic [3:0]        gap_cnt;
  logic              last_bit;
  logic              load;

  always_comb begin
    state_nxt  = state;
    last_bit   = (state == ST_SHIFT) && (bit_cnt == LAST_BIT);
    data_ready = !reset && ((state == ST_IDLE) || ((GAP_CYCLES == 0) && last_bit));
    load       = data_valid && data_ready;
    out_valid  = (state == ST_SHIFT);
    out_seq    = (state == ST_SHIFT) && sr[WIDTH-1];
    frame_done = last_bit;
    case (state)
      ST_IDLE:  if (load) state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (last_bit) begin
          if (GAP_CYCLES > 0) state_nxt = ST_GAP;
          else if (load)      state_nxt = ST_SHIFT;
          else                state_nxt = ST_IDLE;
        end
      end
      ST_GAP:   if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      gap_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (load) begin
        sr      <= data_in;
        bit_cnt <= '0;
      end else if (state == ST_SHIFT) begin
        sr <= {sr[WIDTH-2:0], 1'b0};
        if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
      end
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 4'd1 : 4'd0;
    end
  end

  assign dbg_state = state;

`ifdef SEQ_GEN_PATTERN_CNT_EN
  seq_gen_pattern_cnt u_pattern_cnt (
    .clk         (clk),
    .reset       (reset),
    .bit_in      (out_seq),
    .pattern_cnt (pattern_cnt)
  );
`else
  assign pattern_cnt = 8'd0;
`endif

endmodule
